// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared definitions for the egress transmit framer: frame-word
//            bit positions, DA/SA slice positions inside the first two data
//            words, the framer state encoding and the DA/SA swap helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam int ETH_DATA_W  = 64;
    localparam int ETH_SOP_BIT = 64;
    localparam int ETH_EOP_BIT = 65;
    localparam int ETH_WORD_W  = 66;
    localparam int ETH_CNT_W   = 16;

    // word0 carries DA in its top 48 bits and SA[47:32] in its low 16 bits;
    // word1 carries SA[31:0] in its top 32 bits.
    localparam int ETH_W0_DA_HI  = 63;
    localparam int ETH_W0_DA_LO  = 16;
    localparam int ETH_W0_SAH_HI = 15;
    localparam int ETH_W0_SAH_LO = 0;
    localparam int ETH_W1_SAL_HI = 63;
    localparam int ETH_W1_SAL_LO = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_GAP    = 2'd3
    } eth_tx_state_t;

    typedef struct packed {
        logic [ETH_DATA_W-1:0] w0;
        logic [ETH_DATA_W-1:0] w1;
    } eth_word_pair_t;

    // Exchange the 48-bit DA and SA fields that straddle words 0 and 1.
    // The low half of word1 is payload and passes through untouched.
    function automatic eth_word_pair_t eth_swap_addr(
        input logic [ETH_DATA_W-1:0] w0,
        input logic [ETH_DATA_W-1:0] w1
    );
        eth_word_pair_t r;
        logic [47:0]    da;
        logic [47:0]    sa;
        da   = w0[ETH_W0_DA_HI:ETH_W0_DA_LO];
        sa   = {w0[ETH_W0_SAH_HI:ETH_W0_SAH_LO], w1[ETH_W1_SAL_HI:ETH_W1_SAL_LO]};
        r.w0 = {sa, da[47:32]};
        r.w1 = {da[31:0], w1[ETH_W1_SAL_LO-1:0]};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_outreg.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_outreg
// Purpose  : Output beat register of the transmit framer. Holds data/sop/eop/
//            vld, loads a new beat only when the slot is free or the current
//            beat is being accepted, and freezes while the sink stalls.
// Ports    : clk, resetN       - clock, async active-low reset
//            load_i            - request to load a beat (honoured on canLoad)
//            data_i/sop_i/eop_i- beat to load
//            ready_i           - sink accepts the presented beat
//            data_o/sop_o/eop_o/vld_o - registered output beat
//            canLoad_o         - !vld_o || ready_i
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_outreg
    import eth_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  load_i,
    input  logic [ETH_DATA_W-1:0] data_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  ready_i,
    output logic [ETH_DATA_W-1:0] data_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  vld_o,
    output logic                  canLoad_o
);

    logic [ETH_DATA_W-1:0] data_q;
    logic [ETH_DATA_W-1:0] data_d;
    logic                  sop_q;
    logic                  sop_d;
    logic                  eop_q;
    logic                  eop_d;
    logic                  vld_q;
    logic                  vld_d;

    assign canLoad_o = !vld_q || ready_i;

    always_comb begin
        data_d = data_q;
        sop_d  = sop_q;
        eop_d  = eop_q;
        vld_d  = vld_q;
        // While the sink stalls a valid beat nothing may change.
        if (canLoad_o) begin
            if (load_i) begin
                data_d = data_i;
                sop_d  = sop_i;
                eop_d  = eop_i;
                vld_d  = 1'b1;
            end else begin
                sop_d  = 1'b0;
                eop_d  = 1'b0;
                vld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            data_q <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            sop_q  <= sop_d;
            eop_q  <= eop_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign sop_o  = sop_q;
    assign eop_o  = eop_q;
    assign vld_o  = vld_q;

endmodule
`default_nettype wire

// File: rtl/eth_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_framer
// Purpose  : Egress transmit framer. Pops {eop,sop,data} words from a
//            show-ahead FIFO, swaps DA/SA across the first two words, drives
//            a valid/ready beat stream with a programmable inter-frame gap,
//            flags framing errors and counts frames and errors.
// Ports    : clk, resetN          - clock, async active-low reset
//            inWord, inEmpty      - FIFO head word and empty flag
//            outRdEn              - pop the FIFO head (combinational)
//            outData/outSop/outEop/outVld - transmit beat
//            inReady              - sink accepts the beat
//            frameCnt, errCnt     - saturating frame / framing-error counters
//            busy                 - frame in progress or beat pending
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES = 2,
    parameter bit SWAP_ADDR  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [ETH_WORD_W-1:0] inWord,
    input  logic                  inEmpty,
    output logic                  outRdEn,
    output logic [ETH_DATA_W-1:0] outData,
    output logic                  outSop,
    output logic                  outEop,
    output logic                  outVld,
    input  logic                  inReady,
    output logic [ETH_CNT_W-1:0]  frameCnt,
    output logic [ETH_CNT_W-1:0]  errCnt,
    output logic                  busy
);

    localparam logic [ETH_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [15:0]          c_IFG_SAT  = 16'(IFG_CYCLES);
    // A SOP beat loaded this cycle appears next cycle, so the current
    // (idle) cycle already counts toward the gap.
    localparam logic [15:0]          c_IFG_MIN1 = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

    eth_tx_state_t          state_q;
    eth_tx_state_t          state_d;
    logic [ETH_WORD_W-1:0]  h_q;
    logic [ETH_WORD_W-1:0]  h_d;
    logic [ETH_CNT_W-1:0]   frameCnt_q;
    logic [ETH_CNT_W-1:0]   frameCnt_d;
    logic [ETH_CNT_W-1:0]   errCnt_q;
    logic [ETH_CNT_W-1:0]   errCnt_d;
    logic [15:0]            ifgCnt_q;
    logic [15:0]            ifgCnt_d;

    logic                   w_rdEn;
    logic                   w_load;
    logic [ETH_DATA_W-1:0]  w_ldData;
    logic                   w_ldSop;
    logic                   w_ldEop;
    logic                   w_errInc;
    logic                   w_canLoad;
    logic                   w_acceptEop;
    logic                   w_ifgOk;
    logic                   w_inSop;
    logic                   w_inEop;
    eth_word_pair_t         w_swp;
    logic [ETH_DATA_W-1:0]  w_first;
    logic [ETH_DATA_W-1:0]  w_second;

    assign w_inSop     = inWord[ETH_SOP_BIT];
    assign w_inEop     = inWord[ETH_EOP_BIT];
    assign w_swp       = eth_swap_addr(h_q[ETH_DATA_W-1:0], inWord[ETH_DATA_W-1:0]);
    assign w_first     = SWAP_ADDR ? w_swp.w0 : h_q[ETH_DATA_W-1:0];
    assign w_second    = SWAP_ADDR ? w_swp.w1 : inWord[ETH_DATA_W-1:0];
    assign w_acceptEop = outVld && inReady && outEop;
    assign w_ifgOk     = (ifgCnt_q >= c_IFG_MIN1);

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        w_rdEn   = 1'b0;
        w_load   = 1'b0;
        w_ldData = h_q[ETH_DATA_W-1:0];
        w_ldSop  = h_q[ETH_SOP_BIT];
        w_ldEop  = h_q[ETH_EOP_BIT];
        w_errInc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!inEmpty) begin
                    if (!w_inSop) begin
                        // Stray word outside a frame: drop it.
                        w_rdEn   = 1'b1;
                        w_errInc = 1'b1;
                    end else if (w_inEop) begin
                        // One-word frame has no SA to swap; send it as is.
                        if (w_canLoad && w_ifgOk) begin
                            w_rdEn   = 1'b1;
                            w_load   = 1'b1;
                            w_ldData = inWord[ETH_DATA_W-1:0];
                            w_ldSop  = 1'b1;
                            w_ldEop  = 1'b1;
                            w_errInc = 1'b1;
                            state_d  = ST_GAP;
                        end
                    end else begin
                        w_rdEn  = 1'b1;
                        h_d     = inWord;
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (!inEmpty && w_canLoad && w_ifgOk) begin
                    w_load  = 1'b1;
                    w_ldSop = 1'b1;
                    if (w_inSop) begin
                        // Next frame started before this one ended: close
                        // the lone header word and leave the SOP queued.
                        w_ldEop  = 1'b1;
                        w_errInc = 1'b1;
                        state_d  = ST_GAP;
                    end else begin
                        w_rdEn   = 1'b1;
                        w_ldData = w_first;
                        w_ldEop  = 1'b0;
                        h_d      = {w_inEop, 1'b0, w_second};
                        state_d  = ST_STREAM;
                    end
                end
            end

            ST_STREAM: begin
                if (h_q[ETH_EOP_BIT]) begin
                    if (w_canLoad) begin
                        w_load  = 1'b1;
                        state_d = ST_GAP;
                    end
                end else if (!inEmpty && w_canLoad) begin
                    w_load = 1'b1;
                    if (w_inSop) begin
                        w_ldEop  = 1'b1;
                        w_errInc = 1'b1;
                        state_d  = ST_GAP;
                    end else begin
                        w_rdEn = 1'b1;
                        h_d    = inWord;
                    end
                end
            end

            ST_GAP: begin
                // The EOP beat leaves once the slot frees up; the gap
                // itself is enforced by ifgCnt before the next SOP load.
                if (w_canLoad) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_comb begin
        frameCnt_d = frameCnt_q;
        errCnt_d   = errCnt_q;
        ifgCnt_d   = ifgCnt_q;
        if (w_acceptEop && (frameCnt_q != c_CNT_MAX)) begin
            frameCnt_d = frameCnt_q + 16'd1;
        end
        if (w_errInc && (errCnt_q != c_CNT_MAX)) begin
            errCnt_d = errCnt_q + 16'd1;
        end
        // Idle output cycles since the last accepted EOP, saturating.
        if (w_acceptEop) begin
            ifgCnt_d = 16'd0;
        end else if (!outVld && (ifgCnt_q < c_IFG_SAT)) begin
            ifgCnt_d = ifgCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            h_q        <= '0;
            frameCnt_q <= '0;
            errCnt_q   <= '0;
            ifgCnt_q   <= c_IFG_SAT;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            frameCnt_q <= frameCnt_d;
            errCnt_q   <= errCnt_d;
            ifgCnt_q   <= ifgCnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    eth_tx_outreg u_outreg (
        .clk       (clk),
        .resetN    (resetN),
        .load_i    (w_load),
        .data_i    (w_ldData),
        .sop_i     (w_ldSop),
        .eop_i     (w_ldEop),
        .ready_i   (inReady),
        .data_o    (outData),
        .sop_o     (outSop),
        .eop_o     (outEop),
        .vld_o     (outVld),
        .canLoad_o (w_canLoad)
    );

    // Gated by resetN so the pop strobe is low while reset is held.
    assign outRdEn  = w_rdEn && resetN;
    assign frameCnt = frameCnt_q;
    assign errCnt   = errCnt_q;
    assign busy     = (state_q != ST_IDLE) || outVld;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_framer
// Purpose  : Scoreboard bench for eth_tx_framer. A FIFO model feeds the DUT;
//            every pushed word also goes through a frame-level reference
//            model that queues the expected beats; a negedge monitor pops
//            and compares each accepted beat and checks stall stability,
//            pop legality and the inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_framer;

    localparam int IFG  = 2;
    localparam bit SWAP = 1'b1;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [65:0] inWord = '0;
    logic        inEmpty = 1'b1;
    logic        outRdEn;
    logic [63:0] outData;
    logic        outSop;
    logic        outEop;
    logic        outVld;
    logic        inReady = 1'b1;
    logic [15:0] frameCnt;
    logic [15:0] errCnt;
    logic        busy;

    eth_tx_framer #(.IFG_CYCLES(IFG), .SWAP_ADDR(SWAP)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inWord   (inWord),
        .inEmpty  (inEmpty),
        .outRdEn  (outRdEn),
        .outData  (outData),
        .outSop   (outSop),
        .outEop   (outEop),
        .outVld   (outVld),
        .inReady  (inReady),
        .frameCnt (frameCnt),
        .errCnt   (errCnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          nCmp = 0;
    int          nErr = 0;
    logic [65:0] fifo[$];
    logic [65:0] expQ[$];
    logic [65:0] mBuf[$];
    bit          mInFrame = 1'b0;
    int          expFrames = 0;
    int          expErrs = 0;
    bit          rdPending = 1'b0;
    bit          gapExact = 1'b0;
    bit          randReady = 1'b0;

    // ---------------- reference model (frame level) ----------------
    task automatic emit_frame(input bit isErr);
        logic [63:0]  d[$];
        logic [127:0] hdr;
        for (int i = 0; i < mBuf.size(); i++) d.push_back(mBuf[i][63:0]);
        if (SWAP && d.size() >= 2) begin
            // Header bytes 0..5 are DA, 6..11 are SA: exchange them.
            hdr  = {d[0], d[1]};
            hdr  = {hdr[79:32], hdr[127:80], hdr[31:0]};
            d[0] = hdr[127:64];
            d[1] = hdr[63:0];
        end
        for (int i = 0; i < d.size(); i++)
            expQ.push_back({(i == d.size() - 1), (i == 0), d[i]});
        expFrames++;
        if (isErr) expErrs++;
        mBuf.delete();
    endtask

    task automatic model_word(input logic [65:0] w);
        if (mInFrame && w[64]) begin
            emit_frame(1'b1);
            mInFrame = 1'b0;
        end
        if (!mInFrame) begin
            if (!w[64]) begin
                expErrs++;
            end else if (w[65]) begin
                mBuf.push_back(w);
                emit_frame(1'b1);
            end else begin
                mBuf.push_back(w);
                mInFrame = 1'b1;
            end
        end else begin
            mBuf.push_back(w);
            if (w[65]) begin
                emit_frame(1'b0);
                mInFrame = 1'b0;
            end
        end
    endtask

    // ---------------- FIFO model / driver ----------------
    task automatic refresh();
        inEmpty = (fifo.size() == 0);
        inWord  = inEmpty ? 66'd0 : fifo[0];
    endtask

    task automatic push_word(input logic [65:0] w);
        fifo.push_back(w);
        model_word(w);
        refresh();
    endtask

    task automatic step_r(input bit rdy);
        @(posedge clk);
        #1;
        if (rdPending && fifo.size() != 0) void'(fifo.pop_front());
        inReady = rdy;
        refresh();
    endtask

    task automatic step();
        step_r(randReady ? ($urandom_range(0, 2) != 0) : 1'b1);
    endtask

    task automatic check_counters(input string tag);
        nCmp++;
        if (frameCnt != 16'(expFrames)) begin
            nErr++;
            $display("FAIL frameCnt_%s: got %0d expected %0d", tag, frameCnt, expFrames);
        end
        nCmp++;
        if (errCnt != 16'(expErrs)) begin
            nErr++;
            $display("FAIL errCnt_%s: got %0d expected %0d", tag, errCnt, expErrs);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((fifo.size() != 0 || expQ.size() != 0 || busy) && n < 400) begin
            step();
            n++;
        end
        nCmp++;
        if (n >= 400) begin
            nErr++;
            $display("FAIL drain_%s: timeout, %0d beats outstanding expected 0", tag, expQ.size());
        end
        check_counters(tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetN = 1'b0;
        fifo.delete();
        expQ.delete();
        mBuf.delete();
        mInFrame  = 1'b0;
        expFrames = 0;
        expErrs   = 0;
        refresh();
        #1;
        nCmp++;
        if ({outVld, outSop, outEop, busy, outRdEn} != 5'b0 || outData != 64'd0) begin
            nErr++;
            $display("FAIL reset_outputs: got vld/sop/eop/busy/rd=%b data=%h expected all 0",
                     {outVld, outSop, outEop, busy, outRdEn}, outData);
        end
        check_counters("reset");
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic push_frame(input int len);
        logic [65:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == len - 1), (i == 0), $urandom(), $urandom()};
            push_word(w);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [65:0] prevBeat = '0;
    bit          prevStall = 1'b0;
    int          bubbles = 0;
    bit          seenEop = 1'b0;

    always @(negedge clk) begin
        logic [65:0] exp;
        if (!resetN) begin
            rdPending = 1'b0;
            prevStall = 1'b0;
            seenEop   = 1'b0;
        end else begin
            rdPending = outRdEn;
            if (outRdEn) begin
                nCmp++;
                if (inEmpty) begin
                    nErr++;
                    $display("FAIL rd_when_empty: got outRdEn=1 expected 0");
                end
            end
            if (prevStall) begin
                nCmp++;
                if (!outVld || {outEop, outSop, outData} != prevBeat) begin
                    nErr++;
                    $display("FAIL stall_hold: got vld=%b beat=%h expected vld=1 beat=%h",
                             outVld, {outEop, outSop, outData}, prevBeat);
                end
            end
            if (outVld && outSop && seenEop) begin
                nCmp++;
                if (bubbles < IFG || (gapExact && bubbles != IFG)) begin
                    nErr++;
                    $display("FAIL ifg: got %0d idle cycles expected %s%0d",
                             bubbles, gapExact ? "" : ">=", IFG);
                end
                seenEop = 1'b0;
            end
            if (!outVld && seenEop) bubbles++;
            if (outVld && inReady) begin
                nCmp++;
                if (expQ.size() == 0) begin
                    nErr++;
                    $display("FAIL beat_unexpected: got %h expected no beat",
                             {outEop, outSop, outData});
                end else begin
                    exp = expQ.pop_front();
                    if ({outEop, outSop, outData} != exp) begin
                        nErr++;
                        $display("FAIL beat: got eop/sop/data=%b/%b/%h expected %b/%b/%h",
                                 outEop, outSop, outData, exp[65], exp[64], exp[63:0]);
                    end
                end
                if (outEop) begin
                    seenEop = 1'b1;
                    bubbles = 0;
                end
            end
            prevStall = outVld && !inReady;
            prevBeat  = {outEop, outSop, outData};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        int  kind;
        bit  found;

        do_reset();

        // DA/SA swap on the reference frame
        randReady = 1'b0;
        push_word(66'h1_0011223344556677);
        push_word(66'h0_8899AABBDEADBEEF);
        push_word(66'h2_0102030405060708);
        drain("swap");

        // same frame with the sink stalling for three cycles
        push_word(66'h1_0011223344556677);
        push_word(66'h0_8899AABBDEADBEEF);
        push_word(66'h2_0102030405060708);
        for (int c = 0; c < 12; c++) step_r(!(c >= 3 && c <= 5));
        drain("backpressure");

        // back-to-back frames: gap must be exactly IFG idle cycles
        push_frame(3);
        push_frame(3);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            step();
            if (outVld && outSop) found = 1'b1;
        end
        nCmp++;
        if (!found) begin
            nErr++;
            $display("FAIL ifg_start: got no SOP within 50 cycles expected one");
        end
        step();
        gapExact = 1'b1;
        drain("ifg");
        gapExact = 1'b0;

        // stray word in IDLE
        push_word(66'h0_5555666677778888);
        drain("stray");

        // SOP arriving mid-frame truncates the running frame
        push_word(66'h1_A1A2A3A4A5A6B1B2);
        push_word(66'h0_B3B4B5B6C0C1C2C3);
        push_word(66'h0_D0D1D2D3D4D5D6D7);
        push_frame(3);
        drain("trunc");

        // single-word frame passes unswapped
        push_word(66'h3_AAAABBBBCCCCDDDD);
        drain("single");

        // reset while the second beat is on the output
        push_frame(4);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            step();
            if (outVld && !outSop) found = 1'b1;
        end
        nCmp++;
        if (!found) begin
            nErr++;
            $display("FAIL reset_mid_wait: got no second beat within 50 cycles expected one");
        end
        do_reset();
        push_word(66'h1_0011223344556677);
        push_word(66'h0_8899AABBDEADBEEF);
        push_word(66'h2_0102030405060708);
        drain("after_reset");

        // randomized traffic with random backpressure
        randReady = 1'b1;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                push_word({1'b0, 1'b0, $urandom(), $urandom()});
            end else if (kind == 1) begin
                push_word({2'b11, $urandom(), $urandom()});
            end else if (kind == 2) begin
                // truncated frame followed directly by a good one
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++)
                    push_word({1'b0, (k == 0), $urandom(), $urandom()});
                push_frame($urandom_range(2, 6));
            end else begin
                push_frame($urandom_range(2, 6));
            end
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) step();
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit framer for the switch egress port. Pops 66-bit frame words `{eop, sop, data[63:0]}` from a show-ahead egress FIFO and swaps the destination and source MAC addresses across the first two words. It drives the 64-bit `data/sop/eop/vld` stream that the receive side consumes, with `outVld`/`inReady` backpressure and a programmable inter-frame gap. It also detects framing errors and keeps frame and error counters.

## Interface
- `IFG_CYCLES`, default 2: idle cycles inserted after each accepted EOP beat (0 is legal).
- `SWAP_ADDR`, default 1: 1 swaps DA/SA; 0 passes data through unchanged with identical latency.
- `clk` in, 1: clock.
- `resetN` in, 1: reset; asynchronous, active-low.
- `inWord` in, 66: FIFO head word; bit 65 = EOP, bit 64 = SOP, bits 63:0 = data. Valid while `!inEmpty`.
- `inEmpty` in, 1: FIFO empty.
- `outRdEn` out, 1: pop the FIFO head this cycle. Combinational; never asserted while `inEmpty`.
- `outData` out, 64: transmit data.
- `outSop` out, 1: first beat of a frame.
- `outEop` out, 1: last beat of a frame.
- `outVld` out, 1: output beat valid.
- `inReady` in, 1: sink accepts the beat; a transfer happens when `outVld && inReady`.
- `frameCnt` out, 16: frames completed (accepted EOP beats), saturating.
- `errCnt` out, 16: framing errors, saturating.
- `busy` out, 1: `state != IDLE || outVld`.

## Operation
- Storage:
  - Output register O holds data, sop, eop and vld.
  - Hold register H holds 66 bits.
- `canLoad = !outVld || inReady`. O loads only when `canLoad`. Otherwise O holds stable, with no change to data, sop or eop while `outVld && !inReady`.
- Word layout:
  - word0[63:16] = DA; word0[15:0] = SA[47:32].
  - word1[63:32] = SA[31:0].
- Swap (`SWAP_ADDR=1`):
  - word0'[63:16] = {word0[15:0], word1[63:32]}.
  - {word0'[15:0], word1'[63:32]} = word0[63:16].
  - word1[31:0] is unchanged.
- States: IDLE, HOLD, STREAM, GAP.
- IDLE, with `!inEmpty`:
  - Head without SOP: pop and discard, `errCnt++`, stay in IDLE.
  - Head with SOP and EOP (1-word frame, too short to swap): when `canLoad`, pop, load O unswapped, `errCnt++`, go to GAP.
  - Head with SOP only: pop into H, go to HOLD.
- HOLD, with `!inEmpty && canLoad`, head word W:
  - W has SOP (truncated frame): do not pop; load O = H with eop forced to 1; `errCnt++`; go to GAP.
  - Otherwise: pop; load O = swapped H (sop=1); H <= swapped W (keeps W.eop); go to STREAM.
- STREAM:
  - H.eop=1: when `canLoad`, load O = H and go to GAP.
  - Otherwise, with `!inEmpty && canLoad`: if W has SOP, load O = H with eop forced, `errCnt++`, go to GAP, no pop. Else load O = H, H <= W, pop.
- GAP:
  - Wait for the EOP beat in O to be accepted.
  - Then count `IFG_CYCLES` cycles with `outVld=0`, then go to IDLE.
  - `IFG_CYCLES=0` allows IDLE on the cycle after acceptance.
- `frameCnt++` on every accepted beat with `outEop=1`, including forced-EOP frames.
- Both counters stick at 0xFFFF.

## Timing
- Reset (async assert): state IDLE, H cleared, counters 0, and all outputs 0: `outData`, `outSop`, `outEop`, `outVld`, `busy`, `outRdEn`. Any frame in flight is dropped.
- Latency: word0 popped at cycle t, word1 popped at t+1, first beat has `outVld=1` at t+2.
- Throughput: one beat per cycle while `inReady=1` and the FIFO is non-empty.
- FIFO underrun mid-frame: insert bubbles (`outVld=0`); no error.
- `outRdEn` is never asserted while `inEmpty` or while `!canLoad`, except the IDLE discard and the IDLE→HOLD capture.
- No new SOP beat leaves before `IFG_CYCLES` idle cycles have elapsed after the previous accepted EOP.

## Structure
- Shared package `eth_pkg` holds:
  - `ETH_SOP_BIT=64`, `ETH_EOP_BIT=65`, `ETH_WORD_W=66`.
  - DA/SA slice constants.
  - State enum `eth_tx_state_t`.
  - Function `eth_swap_addr(w0, w1)`, which returns the swapped pair.
- One sub-module: `eth_tx_outreg`, the O register with the `canLoad` logic and stall behaviour.

## Test plan
- Swap: DA=0x001122334455, SA=0x66778899AABB. Words 0x0011223344556677 (SOP), 0x8899AABBDEADBEEF, 0x0102030405060708 (EOP) → output 0x66778899AABB0011, 0x22334455DEADBEEF, 0x0102030405060708; `frameCnt=1`.
- Backpressure: same frame, `inReady` low on cycles 3–5 → beats held stable, no loss or duplication, same output sequence.
- IFG: two back-to-back 3-word frames, `IFG_CYCLES=2`, `inReady=1` → exactly 2 cycles of `outVld=0` between EOP and the next SOP.
- Errors:
  - Non-SOP word in IDLE → discarded, `errCnt=1`.
  - SOP arriving in STREAM → previous beat emitted with `outEop=1`, `errCnt` increments, new frame sent after the gap.
- Single-word frame 0x3_AAAABBBBCCCCDDDD (SOP and EOP set) → passed unswapped, `errCnt=1`, `frameCnt=1`.
- Reset mid-frame: assert `resetN=0` during the second beat → outputs 0 immediately, counters 0; the next full frame transmits correctly.
